// File: rtl/ctrl_pipeline_pkg.sv
// Shared encodings for the control pipeline: opcodes, operand/writeback
// selector codes, ALU class codes and the decoded control bundle.
package ctrl_pipeline_pkg;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OPC_R      = 7'h33;
    localparam logic [6:0] OPC_I_ARI  = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;

    // ALU operand source selection
    typedef enum logic [1:0] {
        ALU_SRC_RS1_RS2  = 2'b00,
        ALU_SRC_RS1_IMM  = 2'b01,
        ALU_SRC_PC_IMM   = 2'b10,
        ALU_SRC_ZERO_IMM = 2'b11
    } alu_src_e;

    // Writeback source selection
    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_MEM  = 2'b01,
        WB_SEL_PC4  = 2'b10,
        WB_SEL_RSVD = 2'b11
    } wb_sel_e;

    // ALU class codes; zero-extended into the wider ALU op field at EX
    localparam int         ALU_CLASS_W     = 2;
    localparam logic [1:0] ALU_CLASS_ADD   = 2'd0;
    localparam logic [1:0] ALU_CLASS_BR    = 2'd1;
    localparam logic [1:0] ALU_CLASS_FUNCT = 2'd2;

    // Control bundle produced by decode and carried into EX
    typedef struct packed {
        alu_src_e                alu_src;
        logic [ALU_CLASS_W-1:0]  alu_op;
        logic                    branch;
        logic                    jump;
        logic                    mem_read;
        logic                    mem_write;
        logic                    reg_write;
        wb_sel_e                 wb_sel;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '{
        alu_src:   ALU_SRC_RS1_RS2,
        alu_op:    2'd0,
        branch:    1'b0,
        jump:      1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        reg_write: 1'b0,
        wb_sel:    WB_SEL_ALU
    };

endpackage

// File: rtl/ctrl_pipeline_if.sv
// Handshake/control bundle between the ID-stage front end and the control
// pipeline. master drives the ID instruction and stall/flush requests.
interface ctrl_pipeline_if #(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 2
);
    logic                  id_valid;
    logic [6:0]            id_opcode;
    logic [REG_ADDR_W-1:0] id_rd;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  freeze;
    logic                  flush;
    logic                  hazard_stall;
    logic                  id_illegal;
    logic                  ex_valid;
    logic [1:0]            ex_alu_src;
    logic [ALU_OP_W-1:0]   ex_alu_op;
    logic                  ex_branch;
    logic                  ex_jump;
    logic                  mem_valid;
    logic                  mem_read;
    logic                  mem_write;
    logic                  wb_valid;
    logic                  wb_reg_write;
    logic [1:0]            wb_sel;
    logic [REG_ADDR_W-1:0] wb_rd;

    modport master (
        output id_valid, id_opcode, id_rd, id_rs1, id_rs2, freeze, flush,
        input  hazard_stall, id_illegal,
        input  ex_valid, ex_alu_src, ex_alu_op, ex_branch, ex_jump,
        input  mem_valid, mem_read, mem_write,
        input  wb_valid, wb_reg_write, wb_sel, wb_rd
    );

    modport slave (
        input  id_valid, id_opcode, id_rd, id_rs1, id_rs2, freeze, flush,
        output hazard_stall, id_illegal,
        output ex_valid, ex_alu_src, ex_alu_op, ex_branch, ex_jump,
        output mem_valid, mem_read, mem_write,
        output wb_valid, wb_reg_write, wb_sel, wb_rd
    );
endinterface

// File: rtl/ctrl_pipeline_decode.sv
// Combinational RV32I opcode decoder: control bundle, source-register usage
// and a flag telling whether the opcode is in the decode table.
module ctrl_pipeline_decode
    import ctrl_pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [6:0]            opcode_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    output ctrl_bundle_t          ctrl_o,
    output logic                  uses_rs1_o,
    output logic                  uses_rs2_o,
    output logic                  known_o
);

    // Opcode table lookup; writes to x0 never assert reg_write.
    always_comb begin
        ctrl_o     = CTRL_BUBBLE;
        uses_rs1_o = 1'b0;
        uses_rs2_o = 1'b0;
        known_o    = 1'b1;
        case (opcode_i)
            OPC_R: begin
                ctrl_o.alu_op    = ALU_CLASS_FUNCT;
                ctrl_o.reg_write = 1'b1;
                uses_rs1_o       = 1'b1;
                uses_rs2_o       = 1'b1;
            end
            OPC_I_ARI: begin
                ctrl_o.alu_src   = ALU_SRC_RS1_IMM;
                ctrl_o.alu_op    = ALU_CLASS_FUNCT;
                ctrl_o.reg_write = 1'b1;
                uses_rs1_o       = 1'b1;
            end
            OPC_LOAD: begin
                ctrl_o.alu_src   = ALU_SRC_RS1_IMM;
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.wb_sel    = WB_SEL_MEM;
                uses_rs1_o       = 1'b1;
            end
            OPC_STORE: begin
                ctrl_o.alu_src   = ALU_SRC_RS1_IMM;
                ctrl_o.mem_write = 1'b1;
                uses_rs1_o       = 1'b1;
                uses_rs2_o       = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl_o.alu_op    = ALU_CLASS_BR;
                ctrl_o.branch    = 1'b1;
                uses_rs1_o       = 1'b1;
                uses_rs2_o       = 1'b1;
            end
            OPC_JAL: begin
                ctrl_o.alu_src   = ALU_SRC_PC_IMM;
                ctrl_o.jump      = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.wb_sel    = WB_SEL_PC4;
            end
            OPC_JALR: begin
                ctrl_o.alu_src   = ALU_SRC_RS1_IMM;
                ctrl_o.jump      = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.wb_sel    = WB_SEL_PC4;
                uses_rs1_o       = 1'b1;
            end
            OPC_LUI: begin
                ctrl_o.alu_src   = ALU_SRC_ZERO_IMM;
                ctrl_o.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl_o.alu_src   = ALU_SRC_PC_IMM;
                ctrl_o.reg_write = 1'b1;
            end
            default: begin
                ctrl_o  = CTRL_BUBBLE;
                known_o = 1'b0;
            end
        endcase
        ctrl_o.reg_write = ctrl_o.reg_write & (rd_i != {REG_ADDR_W{1'b0}});
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// Control pipeline: decodes the ID instruction and carries its controls through
// EX, MEM and a WB_DELAY-deep writeback line, with load-use stall insertion,
// branch/jump flush (remembered across freeze) and a global freeze.
module ctrl_pipeline
    import ctrl_pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 2,
    parameter int WB_DELAY   = 1
) (
    input  logic          clk,
    input  logic          rst,
    ctrl_pipeline_if.slave bus
);

    ctrl_bundle_t          dec_ctrl_s;
    logic                  dec_uses_rs1_s;
    logic                  dec_uses_rs2_s;
    logic                  dec_known_s;
    logic                  load_use_s;
    logic                  flush_eff_s;

    logic                  ex_valid_q,  ex_valid_d;
    ctrl_bundle_t          ex_ctrl_q,   ex_ctrl_d;
    logic [REG_ADDR_W-1:0] ex_rd_q,     ex_rd_d;
    logic                  flush_pending_q, flush_pending_d;

    logic                  mem_valid_q,     mem_valid_d;
    logic                  mem_read_q,      mem_read_d;
    logic                  mem_write_q,     mem_write_d;
    logic                  mem_reg_write_q, mem_reg_write_d;
    logic [1:0]            mem_wb_sel_q,    mem_wb_sel_d;
    logic [REG_ADDR_W-1:0] mem_rd_q,        mem_rd_d;

    ctrl_pipeline_decode #(.REG_ADDR_W(REG_ADDR_W)) u_decode (
        .opcode_i   (bus.id_opcode),
        .rd_i       (bus.id_rd),
        .ctrl_o     (dec_ctrl_s),
        .uses_rs1_o (dec_uses_rs1_s),
        .uses_rs2_o (dec_uses_rs2_s),
        .known_o    (dec_known_s)
    );

    // Hazard detection: a load in EX whose destination the ID instruction reads.
    always_comb begin
        flush_eff_s = bus.flush | flush_pending_q;
        load_use_s  = bus.id_valid & ex_valid_q & ex_ctrl_q.mem_read &
                      (ex_rd_q != {REG_ADDR_W{1'b0}}) &
                      ((dec_uses_rs1_s & (bus.id_rs1 == ex_rd_q)) |
                       (dec_uses_rs2_s & (bus.id_rs2 == ex_rd_q)));
    end

    assign bus.hazard_stall = load_use_s & ~flush_eff_s;
    assign bus.id_illegal   = bus.id_valid & ~dec_known_s;

    // EX next state: bubble on flush, load-use, empty ID or illegal opcode.
    always_comb begin
        ex_valid_d      = ex_valid_q;
        ex_ctrl_d       = ex_ctrl_q;
        ex_rd_d         = ex_rd_q;
        flush_pending_d = flush_pending_q;
        if (!bus.freeze) begin
            flush_pending_d = 1'b0;
            if (flush_eff_s || load_use_s || !bus.id_valid || !dec_known_s) begin
                ex_valid_d = 1'b0;
                ex_ctrl_d  = CTRL_BUBBLE;
                ex_rd_d    = {REG_ADDR_W{1'b0}};
            end else begin
                ex_valid_d = 1'b1;
                ex_ctrl_d  = dec_ctrl_s;
                ex_rd_d    = bus.id_rd;
            end
        end else begin
            flush_pending_d = flush_pending_q | bus.flush;
        end
    end

    // EX stage register and pending-flush flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q      <= 1'b0;
            ex_ctrl_q       <= CTRL_BUBBLE;
            ex_rd_q         <= {REG_ADDR_W{1'b0}};
            flush_pending_q <= 1'b0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_ctrl_q       <= ex_ctrl_d;
            ex_rd_q         <= ex_rd_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    // MEM next state: EX contents always move on unless frozen (the branch must complete).
    always_comb begin
        mem_valid_d     = mem_valid_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        mem_reg_write_d = mem_reg_write_q;
        mem_wb_sel_d    = mem_wb_sel_q;
        mem_rd_d        = mem_rd_q;
        if (!bus.freeze) begin
            mem_valid_d     = ex_valid_q;
            mem_read_d      = ex_ctrl_q.mem_read;
            mem_write_d     = ex_ctrl_q.mem_write;
            mem_reg_write_d = ex_ctrl_q.reg_write;
            mem_wb_sel_d    = ex_ctrl_q.wb_sel;
            mem_rd_d        = ex_rd_q;
        end else begin
            mem_valid_d     = mem_valid_q;
        end
    end

    // MEM stage register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid_q     <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_reg_write_q <= 1'b0;
            mem_wb_sel_q    <= 2'b00;
            mem_rd_q        <= {REG_ADDR_W{1'b0}};
        end else begin
            mem_valid_q     <= mem_valid_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_reg_write_q <= mem_reg_write_d;
            mem_wb_sel_q    <= mem_wb_sel_d;
            mem_rd_q        <= mem_rd_d;
        end
    end

    // Writeback delay line: stage 0 loads from MEM, stage g from stage g-1.
    for (genvar g = 0; g < WB_DELAY; g++) begin : g_wb
        logic                  v_q,   v_d;
        logic                  rw_q,  rw_d;
        logic [1:0]            sel_q, sel_d;
        logic [REG_ADDR_W-1:0] rd_q,  rd_d;

        if (g == 0) begin : g_head
            assign v_d   = mem_valid_q;
            assign rw_d  = mem_reg_write_q;
            assign sel_d = mem_wb_sel_q;
            assign rd_d  = mem_rd_q;
        end else begin : g_tail
            assign v_d   = g_wb[g-1].v_q;
            assign rw_d  = g_wb[g-1].rw_q;
            assign sel_d = g_wb[g-1].sel_q;
            assign rd_d  = g_wb[g-1].rd_q;
        end

        // One writeback delay stage; holds while frozen.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q   <= 1'b0;
                rw_q  <= 1'b0;
                sel_q <= 2'b00;
                rd_q  <= {REG_ADDR_W{1'b0}};
            end else if (!bus.freeze) begin
                v_q   <= v_d;
                rw_q  <= rw_d;
                sel_q <= sel_d;
                rd_q  <= rd_d;
            end else begin
                v_q   <= v_q;
                rw_q  <= rw_q;
                sel_q <= sel_q;
                rd_q  <= rd_q;
            end
        end
    end

    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_alu_src   = ex_ctrl_q.alu_src;
    assign bus.ex_alu_op    = ALU_OP_W'(ex_ctrl_q.alu_op);
    assign bus.ex_branch    = ex_ctrl_q.branch;
    assign bus.ex_jump      = ex_ctrl_q.jump;
    assign bus.mem_valid    = mem_valid_q;
    assign bus.mem_read     = mem_read_q;
    assign bus.mem_write    = mem_write_q;
    assign bus.wb_valid     = g_wb[WB_DELAY-1].v_q;
    assign bus.wb_reg_write = g_wb[WB_DELAY-1].rw_q;
    assign bus.wb_sel       = g_wb[WB_DELAY-1].sel_q;
    assign bus.wb_rd        = g_wb[WB_DELAY-1].rd_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Self-checking bench for ctrl_pipeline: an instruction-level model of the
// pipeline is checked against the default DUT every cycle, plus directed
// literal checks; a second instance covers a deeper WB line and wider indices.
module tb_ctrl_pipeline;

    localparam logic [6:0] R_OP = 7'h33, I_OP = 7'h13, LD_OP = 7'h03, ST_OP = 7'h23,
                           BR_OP = 7'h63, JAL_OP = 7'h6F, JALR_OP = 7'h67,
                           LUI_OP = 7'h37, AUIPC_OP = 7'h17, BAD_OP = 7'h7F;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ctrl_pipeline_if #(.REG_ADDR_W(5), .ALU_OP_W(2)) bus ();
    ctrl_pipeline_if #(.REG_ADDR_W(6), .ALU_OP_W(2)) bus2 ();

    ctrl_pipeline #(.REG_ADDR_W(5), .ALU_OP_W(2), .WB_DELAY(1)) u_dut (
        .clk(clk), .rst(rst), .bus(bus));
    ctrl_pipeline #(.REG_ADDR_W(6), .ALU_OP_W(2), .WB_DELAY(3)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2));

    int n_cmp = 0;
    int n_bad = 0;

    // One instruction as it sits in a pipeline slot
    typedef struct packed {
        bit       v;
        bit [1:0] src;
        bit [1:0] op;
        bit       br, jp, mr, mw, rw;
        bit [1:0] sel;
        bit [4:0] rd;
    } rec_t;

    rec_t m_ex, m_mem, m_wb;
    bit   m_pend;

    function automatic bit known(input logic [6:0] op);
        return op inside {R_OP, I_OP, LD_OP, ST_OP, BR_OP, JAL_OP, JALR_OP, LUI_OP, AUIPC_OP};
    endfunction

    // Instruction semantics: what each class needs from the datapath.
    function automatic rec_t m_dec(input logic [6:0] op, input logic [4:0] rd);
        rec_t r = '0;
        bit is_mem = (op == LD_OP) || (op == ST_OP);
        bit writes = !(op == ST_OP || op == BR_OP);
        bit uses_pc = (op == JAL_OP) || (op == AUIPC_OP);
        bit uses_imm = !(op == R_OP || op == BR_OP);
        if (!known(op)) return r;
        r.v   = 1'b1;
        r.src = (op == LUI_OP) ? 2'd3 : uses_pc ? 2'd2 : uses_imm ? 2'd1 : 2'd0;
        r.op  = (op == R_OP || op == I_OP) ? 2'd2 : (op == BR_OP) ? 2'd1 : 2'd0;
        r.br  = (op == BR_OP);
        r.jp  = (op == JAL_OP) || (op == JALR_OP);
        r.mr  = (op == LD_OP);
        r.mw  = (op == ST_OP);
        r.rw  = writes && (rd != 5'd0);
        r.sel = r.jp ? 2'd2 : r.mr ? 2'd1 : 2'd0;
        r.rd  = rd;
        if (is_mem) r.op = 2'd0;
        return r;
    endfunction

    function automatic bit m_haz();
        logic [6:0] op = bus.id_opcode;
        bit u1 = op inside {R_OP, I_OP, LD_OP, ST_OP, BR_OP, JALR_OP};
        bit u2 = op inside {R_OP, ST_OP, BR_OP};
        return bus.id_valid && m_ex.v && m_ex.mr && (m_ex.rd != 5'd0) &&
               ((u1 && bus.id_rs1 == m_ex.rd) || (u2 && bus.id_rs2 == m_ex.rd));
    endfunction

    // Reference pipeline: advance one slot per unfrozen edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ex <= '0; m_mem <= '0; m_wb <= '0; m_pend <= 1'b0;
        end else if (!bus.freeze) begin
            m_wb   <= m_mem;
            m_mem  <= m_ex;
            m_pend <= 1'b0;
            if (bus.flush || m_pend || m_haz() || !bus.id_valid)
                m_ex <= '0;
            else
                m_ex <= m_dec(bus.id_opcode, bus.id_rd);
        end else if (bus.flush) begin
            m_pend <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("hazard_stall", bus.hazard_stall, m_haz() && !(bus.flush || m_pend));
        chk("id_illegal",   bus.id_illegal,   bus.id_valid && !known(bus.id_opcode));
        chk("ex_valid",     bus.ex_valid,     m_ex.v);
        chk("ex_alu_src",   bus.ex_alu_src,   m_ex.src);
        chk("ex_alu_op",    bus.ex_alu_op,    m_ex.op);
        chk("ex_branch",    bus.ex_branch,    m_ex.br);
        chk("ex_jump",      bus.ex_jump,      m_ex.jp);
        chk("mem_valid",    bus.mem_valid,    m_mem.v);
        chk("mem_read",     bus.mem_read,     m_mem.mr);
        chk("mem_write",    bus.mem_write,    m_mem.mw);
        chk("wb_valid",     bus.wb_valid,     m_wb.v);
        chk("wb_reg_write", bus.wb_reg_write, m_wb.rw);
        chk("wb_sel",       bus.wb_sel,       m_wb.sel);
        chk("wb_rd",        bus.wb_rd,        m_wb.rd);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    task automatic set_id(input bit v, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2);
        bus.id_valid = v; bus.id_opcode = op; bus.id_rd = rd;
        bus.id_rs1 = rs1; bus.id_rs2 = rs2;
    endtask

    logic [6:0] sweep_op  [10] = '{R_OP, I_OP, LD_OP, ST_OP, BR_OP, JAL_OP, JALR_OP,
                                   LUI_OP, AUIPC_OP, BAD_OP};
    // {ex_valid, alu_src[1:0], alu_op[1:0], branch, jump}
    logic [6:0] sweep_exp [10] = '{7'b1001000, 7'b1011000, 7'b1010000, 7'b1010000,
                                   7'b1000110, 7'b1100001, 7'b1010001, 7'b1110000,
                                   7'b1100000, 7'b0000000};

    initial begin
        set_id(1'b0, 7'h00, 5'd0, 5'd0, 5'd0);
        bus.freeze = 1'b0; bus.flush = 1'b0;
        bus2.id_valid = 1'b0; bus2.id_opcode = 7'h00; bus2.id_rd = 6'd0;
        bus2.id_rs1 = 6'd0; bus2.id_rs2 = 6'd0; bus2.freeze = 1'b0; bus2.flush = 1'b0;
        repeat (2) @(negedge clk);
        compare_model();
        chk("reset_ex_valid", bus.ex_valid, 1'b0);
        chk("reset_wb_valid", bus.wb_valid, 1'b0);
        rst = 1'b0;

        // Three instructions in flight, then an asynchronous reset pulse
        set_id(1'b1, R_OP, 5'd1, 5'd0, 5'd0);  cyc();
        set_id(1'b1, I_OP, 5'd2, 5'd0, 5'd0);  cyc();
        set_id(1'b1, LD_OP, 5'd4, 5'd0, 5'd0); cyc();
        chk("inflight_wb_rd", bus.wb_rd, 5'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_ex_valid", bus.ex_valid, 1'b0);
        chk("async_mem_valid", bus.mem_valid, 1'b0);
        chk("async_wb_valid", bus.wb_valid, 1'b0);
        chk("async_wb_reg_write", bus.wb_reg_write, 1'b0);
        rst = 1'b0;
        set_id(1'b1, R_OP, 5'd3, 5'd0, 5'd0);
        cyc();
        chk("post_reset_ex_valid", bus.ex_valid, 1'b1);
        set_id(1'b0, 7'h00, 5'd0, 5'd0, 5'd0);
        cyc();
        chk("post_reset_wb_early", bus.wb_reg_write, 1'b0);
        cyc();
        chk("post_reset_wb_reg_write", bus.wb_reg_write, 1'b1);
        chk("post_reset_wb_rd", bus.wb_rd, 5'd3);

        // Load-use: LOAD x5 then ADD reading x5
        set_id(1'b1, LD_OP, 5'd5, 5'd0, 5'd0); cyc();
        set_id(1'b1, R_OP, 5'd6, 5'd5, 5'd0);
        #1 chk("loaduse_stall", bus.hazard_stall, 1'b1);
        cyc();
        chk("loaduse_bubble", bus.ex_valid, 1'b0);
        chk("loaduse_load_in_mem", bus.mem_read, 1'b1);
        chk("loaduse_stall_gone", bus.hazard_stall, 1'b0);
        cyc();
        chk("loaduse_add_in_ex", bus.ex_valid, 1'b1);
        chk("loaduse_add_op", bus.ex_alu_op, 2'd2);
        set_id(1'b1, LD_OP, 5'd0, 5'd0, 5'd0); cyc();
        set_id(1'b1, R_OP, 5'd6, 5'd0, 5'd0);
        #1 chk("load_x0_no_stall", bus.hazard_stall, 1'b0);
        cyc();
        chk("load_x0_add_in_ex", bus.ex_valid, 1'b1);

        // Flush with a branch in EX
        set_id(1'b1, BR_OP, 5'd0, 5'd1, 5'd2); cyc();
        chk("branch_in_ex", bus.ex_branch, 1'b1);
        set_id(1'b1, R_OP, 5'd7, 5'd1, 5'd2);
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        chk("flush_ex_bubble", bus.ex_valid, 1'b0);
        chk("flush_branch_in_mem", bus.mem_valid, 1'b1);
        set_id(1'b1, LD_OP, 5'd7, 5'd0, 5'd0); cyc();
        set_id(1'b1, R_OP, 5'd8, 5'd7, 5'd0);
        bus.flush = 1'b1;
        #1 chk("flush_masks_stall", bus.hazard_stall, 1'b0);
        cyc();
        bus.flush = 1'b0;
        chk("flush_over_loaduse_bubble", bus.ex_valid, 1'b0);

        // Flush during freeze is held until the pipeline moves again
        set_id(1'b1, R_OP, 5'd1, 5'd0, 5'd0); cyc();
        set_id(1'b1, I_OP, 5'd2, 5'd0, 5'd0);
        bus.freeze = 1'b1; bus.flush = 1'b1;
        cyc();
        chk("freeze1_ex_held", bus.ex_valid, 1'b1);
        chk("freeze1_src_held", bus.ex_alu_src, 2'd0);
        cyc();
        chk("freeze2_ex_held", bus.ex_valid, 1'b1);
        bus.freeze = 1'b0; bus.flush = 1'b0;
        cyc();
        chk("pending_flush_bubble", bus.ex_valid, 1'b0);
        cyc();
        chk("pending_cleared_ex_valid", bus.ex_valid, 1'b1);
        chk("pending_cleared_src", bus.ex_alu_src, 2'd1);

        // Opcode sweep; the JAL on the second instance rides along
        for (int i = 0; i < 10; i++) begin
            set_id(1'b1, sweep_op[i], 5'd1, 5'd2, 5'd2);
            #1 chk("sweep_illegal", bus.id_illegal, (sweep_op[i] == BAD_OP));
            if (i == 0) begin
                bus2.id_valid = 1'b1; bus2.id_opcode = JAL_OP; bus2.id_rd = 6'd63;
            end
            cyc();
            if (i == 0) bus2.id_valid = 1'b0;
            if (i == 3) chk("dut2_wb_early", bus2.wb_valid, 1'b0);
            if (i == 4) begin
                chk("dut2_wb_valid", bus2.wb_valid, 1'b1);
                chk("dut2_wb_sel", bus2.wb_sel, 2'b10);
                chk("dut2_wb_rd", bus2.wb_rd, 6'd63);
                chk("dut2_wb_reg_write", bus2.wb_reg_write, 1'b1);
            end
            chk("sweep_ex_bundle", {bus.ex_valid, bus.ex_alu_src, bus.ex_alu_op,
                                    bus.ex_branch, bus.ex_jump}, sweep_exp[i]);
        end
        set_id(1'b0, 7'h00, 5'd0, 5'd0, 5'd0);
        repeat (3) cyc();
        chk("drain_wb_valid", bus.wb_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
